// File: rtl/sfx_sequencer.sv
// -----------------------------------------------------------------------------
// sfx_sequencer
//
// Sound-effect generator for the game audio pin. Watches the game event
// outputs (eat pulse, sticky failure level, sticky success level) and plays a
// short fixed note sequence per event as a 1-bit square wave. Note durations
// are counted in millisecond ticks produced by an internal prescaler running
// on the pixel clock.
//
// Ports
//   clk        : clock (VGA pixel clock)
//   rst_n      : synchronous, active-low reset
//   i_eat      : one-cycle pulse, apple eaten            (priority 0)
//   i_failure  : sticky failure level, rising edge fires  (priority 2)
//   i_success  : sticky success level, rising edge fires  (priority 1)
//   i_mute     : forces o_audio low; sequencing keeps running
//   i_volume   : duty level, only used with SFX_VOLUME_PWM_EN
//   o_audio    : registered square-wave audio
//   o_busy     : high while a sequence (notes and gaps) is playing
//
// Parameters
//   TICK_DIV   : clk cycles per 1 ms tick (>= 2)
//   GAP_MS     : silent gap between notes, in ms ticks (0 = no gap)
//   TONE_SHIFT : right shift applied to ROM half-periods
//   DIV_W      : width of the tone half-period counter
//
// Optional feature
//   SFX_VOLUME_PWM_EN : when defined, a free-running 2-bit counter gates the
//                       high phases so that i_volume selects 1/4..4/4 duty.
// -----------------------------------------------------------------------------
module sfx_sequencer #(
   parameter int TICK_DIV   = 25175,
   parameter int GAP_MS     = 10,
   parameter int TONE_SHIFT = 0,
   parameter int DIV_W      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_eat,
   input  logic       i_failure,
   input  logic       i_success,
   input  logic       i_mute,
   input  logic [1:0] i_volume,
   output logic       o_audio,
   output logic       o_busy
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam int MS_W  = 16;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [MS_W-1:0]  GAP_LAST = MS_W'((GAP_MS > 0) ? (GAP_MS - 1) : 0);

   // Sequence id doubles as its priority, so preemption is a plain compare.
   localparam logic [1:0] SEQ_EAT  = 2'd0;
   localparam logic [1:0] SEQ_SUCC = 2'd1;
   localparam logic [1:0] SEQ_FAIL = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Note ROM: half-period in clk cycles, duration in ms, last note index.
   // Address is {sequence id, note index}.
   // ---------------------------------------------------------------------------
   function automatic logic [15:0] rom_half(input logic [1:0] s, input logic [1:0] n);
      logic [15:0] h;
      case ({s, n})
         4'h0:    h = 16'd14304;   // EAT  note 0
         4'h1:    h = 16'd9545;    // EAT  note 1
         4'h4:    h = 16'd19080;   // SUCC note 0
         4'h5:    h = 16'd15120;   // SUCC note 1
         4'h6:    h = 16'd12720;   // SUCC note 2
         4'h7:    h = 16'd9540;    // SUCC note 3
         4'h8:    h = 16'd19080;   // FAIL note 0
         4'h9:    h = 16'd25440;   // FAIL note 1
         4'hA:    h = 16'd38160;   // FAIL note 2
         default: h = 16'd2;
      endcase
      return h;
   endfunction

   function automatic logic [15:0] rom_dur(input logic [1:0] s, input logic [1:0] n);
      logic [15:0] d;
      case ({s, n})
         4'h0:    d = 16'd40;
         4'h1:    d = 16'd60;
         4'h4:    d = 16'd80;
         4'h5:    d = 16'd80;
         4'h6:    d = 16'd80;
         4'h7:    d = 16'd300;
         4'h8:    d = 16'd100;
         4'h9:    d = 16'd100;
         4'hA:    d = 16'd250;
         default: d = 16'd1;
      endcase
      return d;
   endfunction

   function automatic logic [1:0] rom_last(input logic [1:0] s);
      logic [1:0] l;
      case (s)
         SEQ_EAT:  l = 2'd1;
         SEQ_SUCC: l = 2'd3;
         SEQ_FAIL: l = 2'd2;
         default:  l = 2'd0;
      endcase
      return l;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t            state, state_n;
   logic [1:0]        seq, seq_n;
   logic [1:0]        note_idx, note_idx_n;
   logic [DIV_W-1:0]  tone_cnt, tone_cnt_n;
   logic [PRE_W-1:0]  pre_cnt, pre_cnt_n;
   logic [MS_W-1:0]   ms_cnt, ms_cnt_n;
   logic              phase, phase_n;
   logic              fail_q, succ_q;
   logic              audio_n;
   logic              pwm_on;

   // ---------------------------------------------------------------------------
   // Triggers. Only the highest-priority trigger of a cycle is considered; a
   // trigger is taken from IDLE, or during playback when its priority is at
   // least that of the running sequence. Anything else is dropped, never queued.
   // ---------------------------------------------------------------------------
   logic       fail_rise, succ_rise;
   logic       trig_valid;
   logic [1:0] trig_prio;
   logic       accept;

   assign fail_rise  = i_failure & ~fail_q;
   assign succ_rise  = i_success & ~succ_q;
   assign trig_valid = fail_rise | succ_rise | i_eat;
   assign trig_prio  = fail_rise ? SEQ_FAIL : (succ_rise ? SEQ_SUCC : SEQ_EAT);
   assign accept     = trig_valid & ((state == ST_IDLE) | (trig_prio >= seq));

   // ---------------------------------------------------------------------------
   // Current note parameters. Half-period is shifted then clamped to 2 so the
   // tone counter always has at least two states per phase.
   // ---------------------------------------------------------------------------
   logic [31:0]      half_raw;
   logic [DIV_W-1:0] half_last;
   logic [MS_W-1:0]  dur_last;
   logic             pre_tick;

   always_comb begin
      half_raw = 32'(rom_half(seq, note_idx)) >> TONE_SHIFT;
      if (half_raw < 32'd2) begin
         half_raw = 32'd2;
      end
      half_last = DIV_W'(half_raw - 32'd1);
      dur_last  = rom_dur(seq, note_idx) - 16'd1;
   end

   assign pre_tick = (pre_cnt == PRE_LAST);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_n    = state;
      seq_n      = seq;
      note_idx_n = note_idx;
      tone_cnt_n = tone_cnt;
      pre_cnt_n  = pre_cnt;
      ms_cnt_n   = ms_cnt;
      phase_n    = phase;

      if (accept) begin
         // Start (or restart) the selected sequence at note 0.
         state_n    = ST_PLAY;
         seq_n      = trig_prio;
         note_idx_n = 2'd0;
         tone_cnt_n = '0;
         pre_cnt_n  = '0;
         ms_cnt_n   = '0;
         phase_n    = 1'b0;
      end else begin
         case (state)
            ST_PLAY: begin
               if (tone_cnt == half_last) begin
                  tone_cnt_n = '0;
                  phase_n    = ~phase;
               end else begin
                  tone_cnt_n = tone_cnt + DIV_W'(1);
               end

               if (pre_tick) begin
                  pre_cnt_n = '0;
                  if (ms_cnt == dur_last) begin
                     // Note finished: counters and phase restart for whatever
                     // comes next (gap, next note, or idle).
                     ms_cnt_n   = '0;
                     tone_cnt_n = '0;
                     phase_n    = 1'b0;
                     if (note_idx == rom_last(seq)) begin
                        state_n = ST_IDLE;
                     end else begin
                        note_idx_n = note_idx + 2'd1;
                        if (GAP_MS > 0) begin
                           state_n = ST_GAP;
                        end else begin
                           state_n = ST_PLAY;
                        end
                     end
                  end else begin
                     ms_cnt_n = ms_cnt + MS_W'(1);
                  end
               end else begin
                  pre_cnt_n = pre_cnt + PRE_W'(1);
               end
            end

            ST_GAP: begin
               phase_n = 1'b0;
               if (pre_tick) begin
                  pre_cnt_n = '0;
                  if (ms_cnt == GAP_LAST) begin
                     // note_idx already points at the next note.
                     state_n    = ST_PLAY;
                     ms_cnt_n   = '0;
                     tone_cnt_n = '0;
                  end else begin
                     ms_cnt_n = ms_cnt + MS_W'(1);
                  end
               end else begin
                  pre_cnt_n = pre_cnt + PRE_W'(1);
               end
            end

            default: begin
               // IDLE: hold everything until a trigger is accepted.
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Optional volume PWM
   // ---------------------------------------------------------------------------
`ifdef SFX_VOLUME_PWM_EN
   logic [1:0] pwm_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_cnt <= 2'd0;
      end else begin
         pwm_cnt <= pwm_cnt + 2'd1;
      end
   end

   assign pwm_on = (pwm_cnt <= i_volume);
`else
   logic unused_volume;
   assign unused_volume = ^i_volume;
   assign pwm_on        = 1'b1;
`endif

   // Audio is registered from the next-state values so the first rise lands
   // exactly one half-period after PLAY entry; i_mute acts at the next edge.
   assign audio_n = phase_n & (state_n == ST_PLAY) & ~i_mute & pwm_on;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         seq      <= SEQ_EAT;
         note_idx <= 2'd0;
         tone_cnt <= '0;
         pre_cnt  <= '0;
         ms_cnt   <= '0;
         phase    <= 1'b0;
         fail_q   <= 1'b0;
         succ_q   <= 1'b0;
         o_audio  <= 1'b0;
      end else begin
         state    <= state_n;
         seq      <= seq_n;
         note_idx <= note_idx_n;
         tone_cnt <= tone_cnt_n;
         pre_cnt  <= pre_cnt_n;
         ms_cnt   <= ms_cnt_n;
         phase    <= phase_n;
         fail_q   <= i_failure;
         succ_q   <= i_success;
         o_audio  <= audio_n;
      end
   end

   assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sfx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sfx_sequencer
//
// Directed scenarios followed by a randomized phase. Expected audio/busy for
// every cycle come from a schedule model: each sequence is a list of notes
// (duration, half-period) separated by gaps, and the expected output at a
// given offset from sequence start is looked up from that list.
// -----------------------------------------------------------------------------
module tb_sfx_sequencer;

   localparam int TD = 10;   // TICK_DIV
   localparam int GM = 1;    // GAP_MS
   localparam int SH = 8;    // TONE_SHIFT

   logic       clk;
   logic       rst_n;
   logic       i_eat;
   logic       i_failure;
   logic       i_success;
   logic       i_mute;
   logic [1:0] i_volume;
   logic       o_audio;
   logic       o_busy;

   int assert_cnt = 0;
   int fail_cnt   = 0;
   int cyc        = 0;

   // Reference model state
   bit  m_active    = 0;
   int  m_seq       = 0;
   int  m_k         = 0;
   bit  m_prev_fail = 0;
   bit  m_prev_succ = 0;

   logic [1:0] exp_q[$];

   sfx_sequencer #(
      .TICK_DIV   (TD),
      .GAP_MS     (GM),
      .TONE_SHIFT (SH),
      .DIV_W      (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_eat     (i_eat),
      .i_failure (i_failure),
      .i_success (i_success),
      .i_mute    (i_mute),
      .i_volume  (i_volume),
      .o_audio   (o_audio),
      .o_busy    (o_busy)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Sequence tables: 0 = EAT, 1 = SUCC, 2 = FAIL
   // ---------------------------------------------------------------------------
   function automatic int tb_notes(input int s);
      case (s)
         0:       return 2;
         1:       return 4;
         default: return 3;
      endcase
   endfunction

   function automatic int tb_half(input int s, input int n);
      int eat_h[2]  = '{14304, 9545};
      int succ_h[4] = '{19080, 15120, 12720, 9540};
      int fail_h[3] = '{19080, 25440, 38160};
      int h;
      case (s)
         0:       h = eat_h[n];
         1:       h = succ_h[n];
         default: h = fail_h[n];
      endcase
      h = h >> SH;
      return (h < 2) ? 2 : h;
   endfunction

   function automatic int tb_dur(input int s, input int n);
      int eat_d[2]  = '{40, 60};
      int succ_d[4] = '{80, 80, 80, 300};
      int fail_d[3] = '{100, 100, 250};
      case (s)
         0:       return eat_d[n];
         1:       return succ_d[n];
         default: return fail_d[n];
      endcase
   endfunction

   function automatic int tb_total(input int s);
      int t = 0;
      for (int n = 0; n < tb_notes(s); n++) begin
         t += tb_dur(s, n) * TD;
         if (n < tb_notes(s) - 1) t += GM * TD;
      end
      return t;
   endfunction

   // Square phase at offset k (cycles after the accepting edge).
   function automatic bit tb_phase(input int s, input int k);
      int off = k;
      for (int n = 0; n < tb_notes(s); n++) begin
         int len = tb_dur(s, n) * TD;
         if (off < len) return ((off / tb_half(s, n)) % 2) == 1;
         off -= len;
         if (n < tb_notes(s) - 1) begin
            if (off < GM * TD) return 1'b0;
            off -= GM * TD;
         end
      end
      return 1'b0;
   endfunction

   // ---------------------------------------------------------------------------
   // Checks
   // ---------------------------------------------------------------------------
   task automatic check_bit(input string tag, input logic obs, input logic exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // One clock: update the model with the inputs present at the edge, then
   // compare the DUT outputs 1 time unit later.
   // ---------------------------------------------------------------------------
   task automatic step();
      bit         fr, sr, have;
      int         pr;
      logic [1:0] e;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         m_active    = 0;
         m_prev_fail = 0;
         m_prev_succ = 0;
      end else begin
         fr   = i_failure && !m_prev_fail;
         sr   = i_success && !m_prev_succ;
         have = fr || sr || i_eat;
         pr   = fr ? 2 : (sr ? 1 : 0);
         m_prev_fail = i_failure;
         m_prev_succ = i_success;
         if (have && (!m_active || pr >= m_seq)) begin
            m_active = 1;
            m_seq    = pr;
            m_k      = 0;
         end else if (m_active) begin
            m_k++;
            if (m_k >= tb_total(m_seq)) m_active = 0;
         end
      end
      e[1] = m_active;
      e[0] = m_active && !i_mute && tb_phase(m_seq, m_k);
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      check_bit("busy", o_busy, e[1]);
      check_bit("audio", o_audio, e[0]);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (o_busy === 1'b1 && n < max) begin
         step();
         n++;
      end
      check_int("idle_timeout", (o_busy === 1'b1) ? 1 : 0, 0);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int c0;
      int first_rise;
      int busy_cnt;
      int rises;
      int audio_hi;
      logic prev_busy;

      rst_n     = 1'b0;
      i_eat     = 1'b0;
      i_failure = 1'b0;
      i_success = 1'b0;
      i_mute    = 1'b0;
      i_volume  = 2'd3;

      // Reset state
      run(3);
      check_bit("reset_audio", o_audio, 1'b0);
      check_bit("reset_busy", o_busy, 1'b0);
      rst_n = 1'b1;
      run(2);

      // EAT: first rise after 55 cycles, 1010 cycles busy
      i_eat = 1'b1;
      step();
      c0 = cyc;
      i_eat = 1'b0;
      check_bit("eat_busy_start", o_busy, 1'b1);
      first_rise = -1;
      for (int i = 0; i < 1100 && o_busy === 1'b1; i++) begin
         step();
         if (o_audio === 1'b1 && first_rise < 0) first_rise = cyc - c0;
      end
      check_int("eat_first_rise", first_rise, 55);
      check_int("eat_busy_len", cyc - c0, 1010);
      run(5);

      // SUCC held high: one sequence only
      i_success = 1'b1;
      busy_cnt  = 0;
      rises     = 0;
      prev_busy = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         step();
         if (o_busy === 1'b1) busy_cnt++;
         if (o_busy === 1'b1 && prev_busy !== 1'b1) rises++;
         prev_busy = o_busy;
      end
      check_int("succ_busy_len", busy_cnt, 5430);
      check_int("succ_starts", rises, 1);
      i_success = 1'b0;
      run(5);

      // EAT preempted by FAIL; later eat ignored
      i_eat = 1'b1;
      step();
      i_eat = 1'b0;
      run(100);
      i_failure = 1'b1;
      step();
      c0 = cyc;
      run(200);
      i_eat = 1'b1;
      step();
      i_eat = 1'b0;
      wait_idle(5000);
      check_int("fail_preempt_len", cyc - c0, 4520);
      i_failure = 1'b0;
      run(5);

      // Same-cycle eat + failure: FAIL wins
      i_eat     = 1'b1;
      i_failure = 1'b1;
      step();
      c0 = cyc;
      i_eat = 1'b0;
      wait_idle(5000);
      check_int("same_cycle_fail_len", cyc - c0, 4520);
      i_failure = 1'b0;
      run(3);

      // EAT restarted by a second eat
      i_eat = 1'b1;
      step();
      i_eat = 1'b0;
      run(200);
      i_eat = 1'b1;
      step();
      c0 = cyc;
      i_eat = 1'b0;
      wait_idle(2000);
      check_int("eat_restart_len", cyc - c0, 1010);
      run(3);

      // Muted EAT: timing unchanged, audio silent
      i_mute = 1'b1;
      i_eat  = 1'b1;
      step();
      c0 = cyc;
      i_eat = 1'b0;
      audio_hi = 0;
      for (int i = 0; i < 1100 && o_busy === 1'b1; i++) begin
         step();
         if (o_audio === 1'b1) audio_hi++;
      end
      check_int("mute_busy_len", cyc - c0, 1010);
      check_int("mute_audio_hi", audio_hi, 0);
      i_mute = 1'b0;
      run(3);

      // Reset mid-sequence, then failure already high at reset release
      i_eat = 1'b1;
      step();
      i_eat = 1'b0;
      run(300);
      rst_n     = 1'b0;
      i_failure = 1'b1;
      step();
      check_bit("midrst_busy", o_busy, 1'b0);
      check_bit("midrst_audio", o_audio, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      c0 = cyc;
      check_bit("fail_after_reset", o_busy, 1'b1);
      wait_idle(5000);
      check_int("fail_after_reset_len", cyc - c0, 4520);
      i_failure = 1'b0;
      run(5);

      // Randomized phase
      for (int i = 0; i < 20000; i++) begin
         rst_n    = ($urandom_range(0, 7999) != 0);
         i_eat    = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 2999) == 0) i_failure = ~i_failure;
         if ($urandom_range(0, 1999) == 0) i_success = ~i_success;
         if ($urandom_range(0, 499) == 0)  i_mute    = ~i_mute;
         i_volume = 2'($urandom_range(0, 3));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
